// File: rtl/mips_fetch_queue.sv
// Instruction fetch front end: owns fetch PC, buffers {instr, pc+4} pairs; fetched word reaches head 1 cycle later when queue was empty.
// Backpressure: fetch freezes while full unless decode pops the same cycle; redirect flushes and restarts fetch.
module mips_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [ADDR_W-1:0]          im_addr,
  input  logic [DATA_W-1:0]          im_data,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_instruction,
  output logic [ADDR_W-1:0]          deq_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc4   [DEPTH];
  logic              push;
  logic              pop;

  assign pc_plus4  = fetch_pc + ADDR_W'(4);
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign im_addr   = fetch_pc;
  assign deq_valid = ~empty;

  assign pop  = deq_valid & deq_ready & ~redirect;
  assign push = ~redirect & (~full | pop);

  assign deq_instruction = empty ? '0 : mem_instr[rd_ptr];
  assign deq_pc_plus4    = empty ? '0 : mem_pc4[rd_ptr];

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt_q    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= pc_plus4;
        wr_ptr   <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= im_data;
      mem_pc4[wr_ptr]   <= pc_plus4;
    end
  end

endmodule
